// File: rtl/wb_mem_slave.sv
// wb_mem_slave: Wishbone B4 pipelined slave in front of a byte-writable
// word array. Every accepted request gets exactly one response RD_LAT cycles
// later, in accept order. Out-of-range addresses get wb_err_o and never touch
// the array.
//
// Ports:
//   wb_clk_i, wb_rst_i    clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i    bus cycle / request strobe
//   wb_we_i               write request
//   wb_adr_i, wb_sel_i    byte address, byte enables
//   wb_dat_i              write data
//   wb_stall_o            back-pressure, from registered state and wb_cyc_i only
//   wb_ack_o, wb_err_o    one-cycle response strobes
//   wb_dat_o              read data during a read ack, otherwise zero

`ifndef CORE_ADDR_WIDTH
`define CORE_ADDR_WIDTH 32
`endif
`ifndef CORE_DATA_WIDTH
`define CORE_DATA_WIDTH 32
`endif
`ifndef CORE_BE_WIDTH
`define CORE_BE_WIDTH 4
`endif

module wb_mem_slave #(
  parameter int unsigned MEM_AWIDTH = 10,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  input  logic                        wb_we_i,
  input  logic [`CORE_ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [`CORE_BE_WIDTH-1:0]   wb_sel_i,
  input  logic [`CORE_DATA_WIDTH-1:0] wb_dat_i,
  output logic                        wb_stall_o,
  output logic                        wb_ack_o,
  output logic                        wb_err_o,
  output logic [`CORE_DATA_WIDTH-1:0] wb_dat_o
);

  localparam int unsigned DW = `CORE_DATA_WIDTH;
  localparam int unsigned BW = `CORE_BE_WIDTH;
  localparam int unsigned LS = RD_LAT - 1;

  logic [DW-1:0]         r_mem [2**MEM_AWIDTH];
  logic [2:0]            r_cnt;
  logic [RD_LAT-1:0]     r_vld;
  logic [RD_LAT-1:0]     r_err;
  logic [RD_LAT-1:0]     r_we;
  logic [DW-1:0]         r_dat [RD_LAT];

  logic                  w_acc;
  logic                  w_resp;
  logic                  w_oor;
  logic [MEM_AWIDTH-1:0] w_idx;
  logic                  w_unused;

  assign w_idx    = wb_adr_i[MEM_AWIDTH+1:2];
  assign w_oor    = |(wb_adr_i >> (MEM_AWIDTH + 2));
  assign w_unused = &{1'b0, wb_adr_i[1:0]};

  assign wb_stall_o = (r_cnt == 3'(MAX_OUTST)) | ~wb_cyc_i;
  assign w_acc      = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  // Dropping wb_cyc_i kills the response in the same cycle, not just later.
  assign w_resp     = wb_cyc_i & r_vld[LS];

  always_comb begin
    wb_ack_o = w_resp & ~r_err[LS];
    wb_err_o = w_resp &  r_err[LS];
    wb_dat_o = '0;
    if (wb_ack_o && !r_we[LS]) begin
      wb_dat_o = r_dat[LS];
    end
  end

  // Array contents survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (w_acc && wb_we_i && !w_oor) begin
      for (int unsigned i = 0; i < BW; i++) begin
        if (wb_sel_i[i]) begin
          r_mem[w_idx][8*i +: 8] <= wb_dat_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !wb_cyc_i) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_acc;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  // Payload stages need no reset; they are qualified by r_vld.
  always_ff @(posedge wb_clk_i) begin
    r_err[0] <= w_oor;
    r_we[0]  <= wb_we_i;
    r_dat[0] <= (w_oor || wb_we_i) ? '0 : r_mem[w_idx];
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      r_err[i] <= r_err[i-1];
      r_we[i]  <= r_we[i-1];
      r_dat[i] <= r_dat[i-1];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !wb_cyc_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 3'(w_acc) - 3'(w_resp);
    end
  end

endmodule
